// File: rtl/bip_program_loader_if.sv
// rtl/bip_program_loader_if.sv - UART byte input, program memory write port and CPU control of the BIP loader
interface bip_program_loader_if #(
  parameter int ADDRESS_BITS = 11,
  parameter int DATA_BITS    = 16
);
  logic [7:0]              i_rx_data;
  logic                    i_rx_valid;
  logic                    i_bip_done;
  logic                    o_wr_en;
  logic [ADDRESS_BITS-1:0] o_wr_addr;
  logic [DATA_BITS-1:0]    o_wr_data;
  logic                    o_cpu_rst_n;
  logic                    o_loading;
  logic                    o_error;

  modport master (
    input  i_rx_data, i_rx_valid, i_bip_done,
    output o_wr_en, o_wr_addr, o_wr_data, o_cpu_rst_n, o_loading, o_error
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_bip_done,
    input  o_wr_en, o_wr_addr, o_wr_data, o_cpu_rst_n, o_loading, o_error
  );
endinterface

// File: rtl/bip_program_loader.sv
// rtl/bip_program_loader.sv - loads BIP program memory from UART byte pairs, then releases the CPU
module bip_program_loader #(
  parameter int ADDRESS_BITS = 11,
  parameter int DATA_BITS    = 16,
  parameter logic [DATA_BITS-ADDRESS_BITS-1:0] HALT_OPCODE = '0,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  bip_program_loader_if.master bus
);
  localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_BITS-1:0]     TERMINAL  = CNT_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDRESS_BITS-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {WAIT_LO, WAIT_HI, RUN, DRAIN} state_t;

  state_t                  state;
  logic [7:0]              lo_byte;
  logic [CNT_BITS-1:0]     timeout_cnt;
  logic [ADDRESS_BITS-1:0] addr;
  logic                    wr_en;
  logic [ADDRESS_BITS-1:0] wr_addr;
  logic [DATA_BITS-1:0]    wr_data;
  logic                    cpu_rst_n;
  logic                    error;

  logic [DATA_BITS-1:0] word;
  logic                 is_halt;
  logic                 is_last;

  assign word    = DATA_BITS'({bus.i_rx_data, lo_byte});
  assign is_halt = (word[DATA_BITS-1:ADDRESS_BITS] == HALT_OPCODE);
  assign is_last = (addr == LAST_ADDR);

  assign bus.o_wr_en     = wr_en;
  assign bus.o_wr_addr   = wr_addr;
  assign bus.o_wr_data   = wr_data;
  assign bus.o_cpu_rst_n = cpu_rst_n;
  assign bus.o_error     = error;
  assign bus.o_loading   = (state == WAIT_LO) || (state == WAIT_HI);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= WAIT_LO;
      lo_byte     <= '0;
      timeout_cnt <= '0;
      addr        <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      cpu_rst_n   <= 1'b0;
      error       <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      error <= 1'b0;
      case (state)
        WAIT_LO: begin
          if (bus.i_rx_valid) begin
            lo_byte     <= bus.i_rx_data;
            timeout_cnt <= '0;
            state       <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          // A byte arriving on the terminal-count cycle still completes the word.
          if (bus.i_rx_valid) begin
            wr_en   <= 1'b1;
            wr_data <= word;
            wr_addr <= addr;
            if (is_halt || is_last) begin
              state <= RUN;
            end else begin
              addr  <= addr + ADDRESS_BITS'(1);
              state <= WAIT_LO;
            end
          end else if (timeout_cnt == TERMINAL) begin
            error       <= 1'b1;
            lo_byte     <= '0;
            timeout_cnt <= '0;
            state       <= WAIT_LO;
          end else begin
            timeout_cnt <= timeout_cnt + CNT_BITS'(1);
          end
        end
        RUN: begin
          if (bus.i_bip_done) begin
            cpu_rst_n <= 1'b0;
            state     <= DRAIN;
          end else begin
            cpu_rst_n <= 1'b1;
          end
        end
        DRAIN: begin
          // The CPU's done flag only clears while it is held in reset.
          cpu_rst_n <= 1'b0;
          if (!bus.i_bip_done) begin
            addr  <= '0;
            state <= WAIT_LO;
          end
        end
        default: state <= WAIT_LO;
      endcase
    end
  end
endmodule

// File: tb/tb_bip_program_loader.sv
// tb/tb_bip_program_loader.sv - directed bench for bip_program_loader (11-bit and 3-bit address builds)
module tb_bip_program_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int big_err = 0;
  int big_addr_q[$];
  int big_data_q[$];
  int small_addr_q[$];
  int small_data_q[$];

  bip_program_loader_if #(.ADDRESS_BITS(11), .DATA_BITS(16)) big_if ();
  bip_program_loader_if #(.ADDRESS_BITS(3),  .DATA_BITS(16)) small_if ();

  bip_program_loader #(.ADDRESS_BITS(11), .DATA_BITS(16), .HALT_OPCODE(5'b00000),
                       .TIMEOUT_CYCLES(16)) u_big (.clk(clk), .rst(rst), .bus(big_if));
  bip_program_loader #(.ADDRESS_BITS(3), .DATA_BITS(16), .HALT_OPCODE(13'h0000),
                       .TIMEOUT_CYCLES(16)) u_small (.clk(clk), .rst(rst), .bus(small_if));

  always @(negedge clk) begin
    if (big_if.o_wr_en) begin
      big_addr_q.push_back(int'(big_if.o_wr_addr));
      big_data_q.push_back(int'(big_if.o_wr_data));
    end
    if (small_if.o_wr_en) begin
      small_addr_q.push_back(int'(small_if.o_wr_addr));
      small_data_q.push_back(int'(small_if.o_wr_data));
    end
    if (big_if.o_error) big_err++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {wr_en, cpu_rst_n, loading, error}
  function automatic logic [3:0] flags(input bit sel);
    if (sel) return {small_if.o_wr_en, small_if.o_cpu_rst_n, small_if.o_loading, small_if.o_error};
    return {big_if.o_wr_en, big_if.o_cpu_rst_n, big_if.o_loading, big_if.o_error};
  endfunction

  function automatic logic [31:0] wr_addr_of(input bit sel);
    return sel ? 32'(small_if.o_wr_addr) : 32'(big_if.o_wr_addr);
  endfunction

  function automatic logic [31:0] wr_data_of(input bit sel);
    return sel ? 32'(small_if.o_wr_data) : 32'(big_if.o_wr_data);
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin
      small_if.i_rx_valid = v;
      small_if.i_rx_data  = d;
    end else begin
      big_if.i_rx_valid = v;
      big_if.i_rx_data  = d;
    end
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b);
    @(posedge clk); #1;
    drive(sel, 1'b1, b);
    @(posedge clk); #1;
    drive(sel, 1'b0, 8'h00);
  endtask

  // Call right after the final high byte: write cycle, then CPU release.
  task automatic finish_prog(input bit sel, input string tag);
    @(negedge clk);
    check({tag, "_write_cycle"}, 32'(flags(sel)), 32'b1000);
    @(negedge clk);
    check({tag, "_cpu_release"}, 32'(flags(sel)), 32'b0100);
  endtask

  task automatic expect_write(input bit sel, input string tag, input int a, input int d);
    int n;
    int ga;
    int gd;
    n = sel ? small_addr_q.size() : big_addr_q.size();
    check({tag, "_present"}, 32'(n > 0), 32'd1);
    if (n == 0) return;
    if (sel) begin
      ga = small_addr_q.pop_front();
      gd = small_data_q.pop_front();
    end else begin
      ga = big_addr_q.pop_front();
      gd = big_data_q.pop_front();
    end
    check({tag, "_addr"}, 32'(ga), 32'(a));
    check({tag, "_data"}, 32'(gd), 32'(d));
  endtask

  task automatic expect_none(input bit sel, input string tag);
    check({tag, "_no_extra_write"}, 32'(sel ? small_addr_q.size() : big_addr_q.size()), 32'd0);
  endtask

  task automatic check_reset(input bit sel, input string tag);
    check({tag, "_flags"}, 32'(flags(sel)), 32'b0010);
    check({tag, "_addr"}, wr_addr_of(sel), 32'd0);
    check({tag, "_data"}, wr_data_of(sel), 32'd0);
  endtask

  task automatic rearm();
    @(posedge clk); #1 big_if.i_bip_done = 1'b1;
    @(posedge clk); #1 big_if.i_bip_done = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    big_if.i_bip_done   = 1'b0;
    small_if.i_bip_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset(1'b0, "reset_big");
    check_reset(1'b1, "reset_small");
    @(posedge clk); #1 rst = 1'b1;

    // Three-word program ending with HALT
    send_byte(0, 8'h05); send_byte(0, 8'h08);
    send_byte(0, 8'h0A); send_byte(0, 8'h10);
    send_byte(0, 8'h00); send_byte(0, 8'h00);
    finish_prog(0, "prog3");
    expect_write(0, "prog3_w0", 0, 16'h0805);
    expect_write(0, "prog3_w1", 1, 16'h100A);
    expect_write(0, "prog3_w2", 2, 16'h0000);
    expect_none(0, "prog3");
    send_byte(0, 8'h12); send_byte(0, 8'h34);
    repeat (2) @(negedge clk);
    expect_none(0, "run_ignores_rx");

    // Done handshake, bytes in DRAIN dropped, then a one-word HALT program
    @(posedge clk); #1 big_if.i_bip_done = 1'b1;
    @(posedge clk); @(negedge clk);
    check("done_cpu_hold", 32'(flags(0)), 32'b0000);
    send_byte(0, 8'h55);
    @(posedge clk); #1 big_if.i_bip_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rearm_loading", 32'(flags(0)), 32'b0010);
    send_byte(0, 8'h00); send_byte(0, 8'h00);
    finish_prog(0, "reload");
    expect_write(0, "reload_w0", 0, 16'h0000);
    expect_none(0, "reload");

    // Inter-byte timeout: 16 idle cycles after the low byte
    rearm();
    send_byte(0, 8'h34);
    repeat (16) @(posedge clk);
    @(negedge clk);
    check("timeout_pulse", 32'(flags(0)), 32'b0011);
    @(negedge clk);
    check("timeout_one_cycle", 32'(flags(0)), 32'b0010);
    check("timeout_err_count", 32'(big_err), 32'd1);
    expect_none(0, "timeout");
    send_byte(0, 8'h01); send_byte(0, 8'h08);
    send_byte(0, 8'h00); send_byte(0, 8'h00);
    finish_prog(0, "after_to");
    expect_write(0, "after_to_w0", 0, 16'h0801);
    expect_write(0, "after_to_w1", 1, 16'h0000);

    // High byte exactly on the terminal-count cycle wins
    rearm();
    send_byte(0, 8'h22);
    repeat (14) @(posedge clk);
    send_byte(0, 8'h00);
    finish_prog(0, "terminal");
    expect_write(0, "terminal_w0", 0, 16'h0022);
    check("terminal_no_err", 32'(big_err), 32'd1);

    // Reset in WAIT_HI, then reset in RUN
    rearm();
    send_byte(0, 8'h77);
    pulse_reset();
    check_reset(0, "rst_wait_hi");
    send_byte(0, 8'h11); send_byte(0, 8'h08);
    send_byte(0, 8'h00); send_byte(0, 8'h00);
    finish_prog(0, "post_rst");
    expect_write(0, "post_rst_w0", 0, 16'h0811);
    expect_write(0, "post_rst_w1", 1, 16'h0000);
    pulse_reset();
    check_reset(0, "rst_run");
    send_byte(0, 8'h00); send_byte(0, 8'h00);
    finish_prog(0, "post_rst_run");
    expect_write(0, "post_rst_run_w0", 0, 16'h0000);
    expect_none(0, "post_rst_run");

    // 3-bit address build: 8 non-HALT words fill memory and start the CPU
    for (int i = 0; i < 8; i++) begin
      send_byte(1, 8'(8 + i));
      send_byte(1, 8'h00);
    end
    finish_prog(1, "full");
    for (int i = 0; i < 8; i++) expect_write(1, $sformatf("full_w%0d", i), i, 8 + i);
    send_byte(1, 8'h09); send_byte(1, 8'h00);
    repeat (3) @(negedge clk);
    expect_none(1, "full_ninth");
    check("full_still_run", 32'(flags(1)), 32'b0100);
    check("full_addr_hold", wr_addr_of(1), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
